// File: rtl/apb_master_bridge_mc_pkg.sv
// ---------------------------------------------------------------------------
// apb_bridge_pkg
//   Shared definitions for the multi-slave APB master bridge:
//     - state_t        : bridge FSM states
//     - PPROT_*        : bit masks for the three PPROT attribute fields
//     - wait_cnt_width : width of the ACCESS wait-state counter for a given
//                        timeout value (never narrower than one bit)
// ---------------------------------------------------------------------------
package apb_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DECERR = 2'd3
  } state_t;

  // PPROT[0] privileged, PPROT[1] non-secure, PPROT[2] instruction access
  localparam logic [2:0] PPROT_PRIVILEGED  = 3'b001;
  localparam logic [2:0] PPROT_NONSECURE   = 3'b010;
  localparam logic [2:0] PPROT_INSTRUCTION = 3'b100;

  // The counter has to hold the value TIMEOUT itself, hence clog2(TIMEOUT+1).
  // A disabled timeout (0) would give a zero-width vector, so clamp to 1.
  function automatic int wait_cnt_width(input int timeout);
    int w;
    w = $clog2(timeout + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/apb_master_bridge_mc_if.sv
// ---------------------------------------------------------------------------
// apb_master_bridge_mc_if
//   Bundles the request port, the response port and the multi-slave APB bus
//   of the bridge.
//   modport master : the bridge side (drives cmd_ready, rsp_*, APB requests)
//   modport slave  : the system side (drives cmd_*, per-slave PREADY,
//                    PSLVERR and PRDATA)
//   Parameters: ADDR_W, DATA_W, NUM_SLAVES (must match the bridge).
// ---------------------------------------------------------------------------
interface apb_master_bridge_mc_if
  import apb_bridge_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int NUM_SLAVES = 4
) ();

  localparam int STRB_W = DATA_W / 8;

  // request port
  logic                         cmd_valid;
  logic                         cmd_ready;
  logic                         cmd_write;
  logic [ADDR_W-1:0]            cmd_addr;
  logic [DATA_W-1:0]            cmd_wdata;
  logic [STRB_W-1:0]            cmd_wstrb;
  logic [2:0]                   cmd_prot;

  // response port
  logic                         rsp_valid;
  logic [DATA_W-1:0]            rsp_rdata;
  logic                         rsp_err;

  // APB bus
  logic [NUM_SLAVES-1:0]        PSEL;
  logic                         PENABLE;
  logic                         PWRITE;
  logic [ADDR_W-1:0]            PADDR;
  logic [DATA_W-1:0]            PWDATA;
  logic [STRB_W-1:0]            PSTRB;
  logic [2:0]                   PPROT;
  logic [NUM_SLAVES-1:0]        PREADY;
  logic [NUM_SLAVES-1:0]        PSLVERR;
  logic [NUM_SLAVES*DATA_W-1:0] PRDATA;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb, cmd_prot,
    input  PREADY, PSLVERR, PRDATA,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb, cmd_prot,
    output PREADY, PSLVERR, PRDATA,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT
  );

endinterface

// File: rtl/apb_master_bridge_mc_decoder.sv
// ---------------------------------------------------------------------------
// apb_addr_decoder
//   Combinational slave decode of the address select field (the SEL_W most
//   significant address bits).
//   Ports:
//     sel_field  in  SEL_W       address MSBs, addr[ADDR_W-1 -: SEL_W]
//     sel        out NUM_SLAVES  one-hot select, all zero on decode error
//     decode_err out 1           select field addresses no existing slave
// ---------------------------------------------------------------------------
module apb_addr_decoder
  import apb_bridge_pkg::*;
#(
  parameter int NUM_SLAVES = 4,
  parameter int SEL_W      = 2
) (
  input  logic [SEL_W-1:0]      sel_field,
  output logic [NUM_SLAVES-1:0] sel,
  output logic                  decode_err
);

  // Only the low NUM_SLAVES codes of the select field map to a slave; any
  // higher code leaves every select bit clear and flags a decode error.
  always_comb begin
    sel        = '0;
    decode_err = (int'(sel_field) >= NUM_SLAVES);
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (int'(sel_field) == i) begin
        sel[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/apb_master_bridge_mc.sv
// ---------------------------------------------------------------------------
// apb_master_bridge_mc
//   Multi-slave APB master bridge. Accepts one command at a time on a
//   valid/ready request port, runs a SETUP -> ACCESS APB transfer to the
//   slave selected by the address MSBs and returns read data plus an error
//   flag on a one-cycle response pulse. Unmapped addresses and slaves that
//   hold PREADY low for TIMEOUT ACCESS cycles are answered with an error.
//   Ports:
//     PCLK     in  APB clock, rising edge
//     PRESETn  in  asynchronous active-low reset
//     bus      apb_master_bridge_mc_if.master: request, response, APB bus
//   Parameters: ADDR_W, DATA_W (8/16/32), NUM_SLAVES (1..16), SEL_W,
//               TIMEOUT (0 disables the wait-state timeout)
// ---------------------------------------------------------------------------
module apb_master_bridge_mc
  import apb_bridge_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int NUM_SLAVES = 4,
  parameter int SEL_W      = 2,
  parameter int TIMEOUT    = 256
) (
  input logic                   PCLK,
  input logic                   PRESETn,
  apb_master_bridge_mc_if.master bus
);

  localparam int STRB_W = DATA_W / 8;
  localparam int CNT_W  = wait_cnt_width(TIMEOUT);

  state_t                state_q;
  state_t                next_state;

  logic [ADDR_W-1:0]     paddr_q;
  logic [DATA_W-1:0]     pwdata_q;
  logic [STRB_W-1:0]     pstrb_q;
  logic [2:0]            pprot_q;
  logic                  pwrite_q;
  logic [NUM_SLAVES-1:0] sel_q;

  logic [CNT_W-1:0]      wait_q;
  logic [CNT_W-1:0]      wait_inc;
  logic                  timeout_hit;

  logic                  rsp_valid_q;
  logic                  rsp_err_q;
  logic [DATA_W-1:0]     rsp_rdata_q;

  logic [NUM_SLAVES-1:0] dec_sel;
  logic                  dec_err;

  logic                  slave_ready;
  logic                  slave_err;
  logic [DATA_W-1:0]     slave_rdata;

  logic                  accept;
  logic                  complete;
  logic                  abort;

  apb_addr_decoder #(
    .NUM_SLAVES (NUM_SLAVES),
    .SEL_W      (SEL_W)
  ) u_decoder (
    .sel_field  (bus.cmd_addr[ADDR_W-1 -: SEL_W]),
    .sel        (dec_sel),
    .decode_err (dec_err)
  );

  // Only the selected slave's PREADY/PSLVERR/PRDATA reach the FSM. sel_q is
  // one-hot (or zero), so a simple priority-free loop acts as the mux.
  always_comb begin
    slave_ready = 1'b0;
    slave_err   = 1'b0;
    slave_rdata = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (sel_q[i]) begin
        slave_ready = bus.PREADY[i];
        slave_err   = bus.PSLVERR[i];
        slave_rdata = bus.PRDATA[i*DATA_W +: DATA_W];
      end
    end
  end

  // The counter counts ACCESS cycles with PREADY low; the abort fires on the
  // cycle whose increment would make it reach TIMEOUT.
  assign wait_inc    = wait_q + CNT_W'(1);
  assign timeout_hit = (TIMEOUT != 0) && (wait_inc == CNT_W'(TIMEOUT));

  // Next-state logic. PREADY is tested before the timeout so that a slave
  // answering in the very cycle the limit is reached still completes.
  always_comb begin
    next_state = state_q;
    accept     = 1'b0;
    complete   = 1'b0;
    abort      = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          accept     = 1'b1;
          next_state = dec_err ? DECERR : SETUP;
        end
      end
      SETUP: begin
        next_state = ACCESS;
      end
      ACCESS: begin
        if (slave_ready) begin
          complete   = 1'b1;
          next_state = IDLE;
        end else if (timeout_hit) begin
          abort      = 1'b1;
          next_state = IDLE;
        end
      end
      DECERR: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q <= IDLE;
    end else begin
      state_q <= next_state;
    end
  end

  // Command capture. The APB-facing registers only change on accept, so
  // PADDR/PWDATA/PSTRB/PPROT/PWRITE keep their last values while idle.
  // Strobes are forced to zero for reads at capture time.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      paddr_q  <= '0;
      pwdata_q <= '0;
      pstrb_q  <= '0;
      pprot_q  <= '0;
      pwrite_q <= 1'b0;
      sel_q    <= '0;
    end else if (accept) begin
      paddr_q  <= bus.cmd_addr;
      pwdata_q <= bus.cmd_wdata;
      pstrb_q  <= bus.cmd_write ? bus.cmd_wstrb : '0;
      pprot_q  <= bus.cmd_prot;
      pwrite_q <= bus.cmd_write;
      sel_q    <= dec_sel;
    end
  end

  // Wait-state counter: cleared when a command is accepted (entry to SETUP)
  // and advanced for every ACCESS cycle the slave is not ready. It is left
  // untouched when the timeout is disabled so it can never wrap.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      wait_q <= '0;
    end else if (accept) begin
      wait_q <= '0;
    end else if (state_q == ACCESS && !slave_ready && TIMEOUT != 0) begin
      wait_q <= wait_inc;
    end
  end

  // Response register. A decode error is flagged from the accept cycle so
  // the pulse coincides with the DECERR state; completion and abort are
  // flagged from the last ACCESS cycle so the pulse follows it. Read data
  // is only passed through for an error-free read.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      rsp_valid_q <= (accept && dec_err) || complete || abort;
      rsp_err_q   <= (accept && dec_err) || abort || (complete && slave_err);
      rsp_rdata_q <= (complete && !pwrite_q && !slave_err) ? slave_rdata : '0;
    end
  end

  // PSEL/PENABLE are decoded from the state so an asynchronous reset drops
  // them immediately.
  assign bus.cmd_ready = (state_q == IDLE);
  assign bus.PSEL      = (state_q == SETUP || state_q == ACCESS) ? sel_q : '0;
  assign bus.PENABLE   = (state_q == ACCESS);
  assign bus.PWRITE    = pwrite_q;
  assign bus.PADDR     = paddr_q;
  assign bus.PWDATA    = pwdata_q;
  assign bus.PSTRB     = pstrb_q;
  assign bus.PPROT     = pprot_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_apb_master_bridge_mc.sv
// ---------------------------------------------------------------------------
// tb_apb_master_bridge_mc
//   Self-checking bench for apb_master_bridge_mc, configured with three
//   slaves (select code 3 is unmapped) and an 8-cycle wait-state timeout.
//   Each transaction's expected cycle-by-cycle bus behaviour and response
//   are derived from the transfer's address, wait-state count and slave
//   error flag; non-target slaves drive random PREADY/PSLVERR/PRDATA.
// ---------------------------------------------------------------------------
module tb_apb_master_bridge_mc;
  import apb_bridge_pkg::*;

  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int NUM_SLAVES = 3;
  localparam int SEL_W      = 2;
  localparam int TIMEOUT    = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  int checks_total  = 0;
  int checks_passed = 0;

  always #5 clk = ~clk;

  apb_master_bridge_mc_if #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .NUM_SLAVES (NUM_SLAVES)
  ) bus ();

  apb_master_bridge_mc #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .NUM_SLAVES (NUM_SLAVES),
    .SEL_W      (SEL_W),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .PCLK    (clk),
    .PRESETn (rst_n),
    .bus     (bus)
  );

  task automatic check_output(input string tag, input logic [63:0] actual,
                              input logic [63:0] expected);
    checks_total++;
    if (actual === expected) begin
      checks_passed++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t",
               tag, actual, expected, $time);
    end
  endtask

  // All slaves get random responses; the target (if >= 0) is then forced.
  task automatic drive_slaves(input int target, input logic tgt_ready,
                              input logic tgt_err, input logic [31:0] tgt_rdata);
    for (int i = 0; i < NUM_SLAVES; i++) begin
      bus.PREADY[i]                  = 1'($urandom);
      bus.PSLVERR[i]                 = 1'($urandom);
      bus.PRDATA[i*DATA_W +: DATA_W] = $urandom;
    end
    if (target >= 0) begin
      bus.PREADY[target]                  = tgt_ready;
      bus.PSLVERR[target]                 = tgt_err;
      bus.PRDATA[target*DATA_W +: DATA_W] = tgt_rdata;
    end
  endtask

  // Junk on the command inputs while the bridge is busy must be ignored.
  task automatic scramble_cmd();
    bus.cmd_write = 1'($urandom);
    bus.cmd_addr  = $urandom;
    bus.cmd_wdata = $urandom;
    bus.cmd_wstrb = 4'($urandom);
    bus.cmd_prot  = 3'($urandom);
  endtask

  task automatic present_cmd(input logic wr, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [3:0] strb,
                             input logic [2:0] prot);
    check_output("cmd_ready_before_issue", bus.cmd_ready, 1);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = addr;
    bus.cmd_wdata = wdata;
    bus.cmd_wstrb = strb;
    bus.cmd_prot  = prot;
  endtask

  task automatic idle_cycles(input int n);
    for (int c = 0; c < n; c++) begin
      bus.cmd_valid = 1'b0;
      scramble_cmd();
      drive_slaves(-1, 1'b0, 1'b0, 32'h0);
      @(posedge clk); #1;
      check_output("idle_rsp_valid", bus.rsp_valid, 0);
      check_output("idle_cmd_ready", bus.cmd_ready, 1);
      check_output("idle_psel", bus.PSEL, 0);
      check_output("idle_penable", bus.PENABLE, 0);
    end
  endtask

  // One complete transfer. Starts in an IDLE cycle (#1 after an edge) and
  // returns in the response cycle (or the cycle after a decode error), so a
  // following call issues at the minimum interval.
  // Cycle k after the accept edge: 1 = SETUP, 2..n+1 = ACCESS, n+2 = rsp,
  // where n = waits+1 if the slave answers before the timeout, else TIMEOUT.
  task automatic run_txn(input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] strb,
                         input logic [2:0] prot, input int waits,
                         input logic slverr, input logic [31:0] rdata);
    int                    idx       = int'(addr[31:30]);
    bit                    decerr    = (idx >= NUM_SLAVES);
    bit                    timed_out = !decerr && (waits >= TIMEOUT);
    int                    n_access  = (waits < TIMEOUT) ? waits + 1 : TIMEOUT;
    int                    last      = decerr ? 1 : n_access + 2;
    logic [NUM_SLAVES-1:0] exp_sel   = decerr ? '0 : NUM_SLAVES'(1 << idx);
    logic                  exp_err   = decerr || timed_out || slverr;
    logic [31:0]           exp_rdata = (decerr || timed_out || wr || slverr) ? 32'h0 : rdata;
    logic [3:0]            exp_strb  = wr ? strb : 4'h0;

    present_cmd(wr, addr, wdata, strb, prot);
    drive_slaves(-1, 1'b0, 1'b0, 32'h0);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    scramble_cmd();

    for (int k = 1; k <= last; k++) begin
      bit   in_setup  = !decerr && (k == 1);
      bit   in_access = !decerr && (k >= 2) && (k <= n_access + 1);
      bit   in_rsp    = (k == last);
      logic tgt_ready;

      check_output("psel", bus.PSEL, (in_setup || in_access) ? exp_sel : '0);
      check_output("penable", bus.PENABLE, in_access);
      check_output("rsp_valid", bus.rsp_valid, in_rsp);
      check_output("cmd_ready", bus.cmd_ready, !decerr && in_rsp);
      if (in_setup || in_access) begin
        check_output("paddr", bus.PADDR, addr);
        check_output("pwrite", bus.PWRITE, wr);
        check_output("pstrb", bus.PSTRB, exp_strb);
        check_output("pprot", bus.PPROT, prot);
        if (wr) check_output("pwdata", bus.PWDATA, wdata);
      end
      if (in_rsp) begin
        check_output("rsp_err", bus.rsp_err, exp_err);
        check_output("rsp_rdata", bus.rsp_rdata, exp_rdata);
        if (!decerr) check_output("paddr_hold", bus.PADDR, addr);
      end

      // Slave answers in ACCESS cycle waits+1; before that it is not ready.
      tgt_ready = in_access ? ((k - 1) > waits) : 1'($urandom);
      drive_slaves(decerr ? -1 : idx, tgt_ready,
                   (in_access && tgt_ready) ? slverr : 1'($urandom), rdata);
      if (k < last) begin
        @(posedge clk); #1;
      end
    end

    if (decerr) begin
      @(posedge clk); #1;
      check_output("decerr_rsp_single", bus.rsp_valid, 0);
      check_output("decerr_cmd_ready", bus.cmd_ready, 1);
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.cmd_valid = 1'b0;
    scramble_cmd();
    drive_slaves(-1, 1'b0, 1'b0, 32'h0);

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check_output("reset_cmd_ready", bus.cmd_ready, 1);
    check_output("reset_psel", bus.PSEL, 0);
    check_output("reset_penable", bus.PENABLE, 0);
    check_output("reset_rsp_valid", bus.rsp_valid, 0);
    check_output("reset_paddr", bus.PADDR, 0);
    check_output("reset_pstrb", bus.PSTRB, 0);
    check_output("reset_rsp_rdata", bus.rsp_rdata, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // zero-wait write to slave 0
    run_txn(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, PPROT_PRIVILEGED, 0, 1'b0, $urandom);
    idle_cycles(1);
    // read from slave 2 with three wait states
    run_txn(1'b0, 32'h8000_0040, $urandom, 4'hA, PPROT_NONSECURE, 3, 1'b0, 32'h1234_5678);
    // unmapped select code 3
    run_txn(1'b1, 32'hC000_0000, $urandom, 4'h3, PPROT_INSTRUCTION, 0, 1'b0, $urandom);
    // slave 1 stuck not-ready: timeout, then the next command is accepted
    run_txn(1'b0, 32'h4000_0000, $urandom, 4'h0, 3'b000, 1000, 1'b0, 32'hCAFE_F00D);
    // slave answers in the very cycle the timeout is reached
    run_txn(1'b0, 32'h4000_0004, $urandom, 4'h0, 3'b011, TIMEOUT - 1, 1'b0, 32'h0BAD_CAFE);
    // read with slave error
    run_txn(1'b0, 32'h4000_0008, $urandom, 4'h0, 3'b000, 0, 1'b1, 32'hFFFF_0001);
    idle_cycles(2);

    // reset in the middle of an ACCESS phase
    present_cmd(1'b0, 32'h4000_0100, 32'h0, 4'h0, 3'b000);
    drive_slaves(1, 1'b0, 1'b0, 32'h5555_AAAA);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    drive_slaves(1, 1'b0, 1'b0, 32'h5555_AAAA);
    @(posedge clk); #1;
    check_output("pre_reset_penable", bus.PENABLE, 1);
    rst_n = 1'b0;
    #1;
    check_output("async_reset_psel", bus.PSEL, 0);
    check_output("async_reset_penable", bus.PENABLE, 0);
    check_output("async_reset_rsp_valid", bus.rsp_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle_cycles(3);

    // randomized traffic with random idle gaps
    for (int t = 0; t < 60; t++) begin
      run_txn(1'($urandom), $urandom, $urandom, 4'($urandom), 3'($urandom),
              $urandom_range(0, 9), ($urandom_range(0, 3) == 0), $urandom);
      idle_cycles($urandom_range(0, 2));
    end

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
